systolic_job_arbiter: RTL and testbench

Front-end controller that shares one `topSystolicArray` instance between `R` independent requesters. It round-robin arbitrates operand submissions and latches the winning A/B matrices. It launches the array with a single-cycle `o_validInput` pulse, waits for the array's result (bounded by a watchdog), then returns `C` to the owning requester over a valid/ready response channel. Only one job is in flight at a time; the array is never re-launched while busy.

---
 rtl/systolic_pkg.sv | 24 ++
 rtl/systolic_job_arbiter_rr_arbiter.sv | 31 +++
 rtl/systolic_job_arbiter.sv | 127 ++++++++++++
 tb/tb_systolic_job_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic job arbiter slice.
// Default sizing matches the 4x4 array instance used on the lab board.
package systolic_pkg;

  localparam int DEF_N       = 4;
  localparam int DEF_TIMEOUT = 16 * DEF_N;
  localparam int WD_W        = $clog2(DEF_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    RESPOND
  } state_t;

  typedef logic [DEF_N-1:0][DEF_N-1:0][7:0]  operand_t;
  typedef logic [DEF_N-1:0][DEF_N-1:0][31:0] result_t;

  // Watchdog width for an arbitrary TIMEOUT; WD_W is the default-sized value.
  function automatic int wdWidth(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/systolic_job_arbiter_rr_arbiter.sv
// Combinational rotate-priority arbiter: first asserted request at or after
// i_ptr, wrapping around, wins.
module rr_arbiter #(
  parameter int R  = 2,
  parameter int PW = 1
) (
  input  logic [R-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [R-1:0]  o_grant,
  output logic [PW-1:0] o_grantIdx
);

  int   idx;
  logic found;

  always_comb begin
    o_grant    = '0;
    o_grantIdx = '0;
    found      = 1'b0;
    idx        = 0;
    for (int off = 0; off < R; off++) begin
      idx = (int'(i_ptr) + off) % R;
      if (!found && i_req[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        o_grantIdx   = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/systolic_job_arbiter.sv
// Shares one systolic array between R requesters: round-robin accept, single
// launch pulse, watchdog-bounded wait, then a valid/ready response to the owner.
module systolic_job_arbiter
  import systolic_pkg::*;
#(
  parameter int N       = 4,
  parameter int R       = 2,
  parameter int TIMEOUT = 16 * N
) (
  input  logic                                  i_clk,
  input  logic                                  i_arst,
  input  logic [R-1:0]                          i_reqValid,
  output logic [R-1:0]                          o_reqReady,
  input  logic [R-1:0][N-1:0][N-1:0][7:0]       i_reqA,
  input  logic [R-1:0][N-1:0][N-1:0][7:0]       i_reqB,
  output logic [R-1:0]                          o_rspValid,
  input  logic [R-1:0]                          i_rspReady,
  output logic [N-1:0][N-1:0][31:0]             o_rspC,
  output logic                                  o_rspErr,
  output logic [N-1:0][N-1:0][7:0]              o_a,
  output logic [N-1:0][N-1:0][7:0]              o_b,
  output logic                                  o_validInput,
  input  logic [N-1:0][N-1:0][31:0]             i_c,
  input  logic                                  i_validResult
);

  localparam int PW  = (R > 1) ? $clog2(R) : 1;
  localparam int WdW = wdWidth(TIMEOUT);

  state_t                      state_q, state_d;
  logic [PW-1:0]               ptr_q, ptr_d;
  logic [PW-1:0]               id_q, id_d;
  logic [N-1:0][N-1:0][7:0]    a_q, a_d;
  logic [N-1:0][N-1:0][7:0]    b_q, b_d;
  logic [N-1:0][N-1:0][31:0]   c_q, c_d;
  logic                        err_q, err_d;
  logic [WdW-1:0]              wd_q, wd_d;

  logic [R-1:0]                grant;
  logic [PW-1:0]               grantIdx;

  rr_arbiter #(
    .R  (R),
    .PW (PW)
  ) u_arb (
    .i_req      (i_reqValid),
    .i_ptr      (ptr_q),
    .o_grant    (grant),
    .o_grantIdx (grantIdx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    err_d   = err_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          a_d     = i_reqA[grantIdx];
          b_d     = i_reqB[grantIdx];
          id_d    = grantIdx;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        wd_d    = '0;
        state_d = BUSY;
      end
      BUSY: begin
        wd_d = wd_q + WdW'(1);
        // A result arriving on the last watchdog cycle still counts as success.
        if (i_validResult) begin
          c_d     = i_c;
          err_d   = 1'b0;
          state_d = RESPOND;
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          c_d     = '0;
          err_d   = 1'b1;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        if (i_rspReady[id_q]) begin
          ptr_d   = (id_q == PW'(R - 1)) ? '0 : id_q + PW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  assign o_reqReady   = (state_q == IDLE) ? grant : '0;
  assign o_validInput = (state_q == LAUNCH);
  assign o_rspValid   = (state_q == RESPOND) ? (R'(1) << id_q) : '0;
  assign o_rspC       = c_q;
  assign o_rspErr     = (state_q == RESPOND) && err_q;
  assign o_a          = a_q;
  assign o_b          = b_q;

endmodule

// File: tb/tb_systolic_job_arbiter.sv
// Scoreboard bench for systolic_job_arbiter with a behavioural stand-in for the
// array (fixed latency, optionally silent, optionally injecting stray strobes).
module tb_systolic_job_arbiter;
  import systolic_pkg::*;

  localparam int N       = 4;
  localparam int R       = 2;
  localparam int TIMEOUT = 16 * N;
  localparam int LAT     = 3 * N;

  logic                             i_clk;
  logic                             i_arst;
  logic [R-1:0]                     i_reqValid;
  logic [R-1:0]                     o_reqReady;
  logic [R-1:0][N-1:0][N-1:0][7:0]  i_reqA;
  logic [R-1:0][N-1:0][N-1:0][7:0]  i_reqB;
  logic [R-1:0]                     o_rspValid;
  logic [R-1:0]                     i_rspReady;
  result_t                          o_rspC;
  logic                             o_rspErr;
  operand_t                         o_a;
  operand_t                         o_b;
  logic                             o_validInput;
  result_t                          i_c;
  logic                             i_validResult;

  typedef struct {
    int      id;
    logic    err;
    result_t c;
  } expT;

  expT     expQ[$];
  int      checkCount = 0;
  int      passCount  = 0;
  int      pulseCount = 0;
  int      staleReq   = 0;
  logic    arrayEnable;

  systolic_job_arbiter #(
    .N       (N),
    .R       (R),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk         (i_clk),
    .i_arst        (i_arst),
    .i_reqValid    (i_reqValid),
    .o_reqReady    (o_reqReady),
    .i_reqA        (i_reqA),
    .i_reqB        (i_reqB),
    .o_rspValid    (o_rspValid),
    .i_rspReady    (i_rspReady),
    .o_rspC        (o_rspC),
    .o_rspErr      (o_rspErr),
    .o_a           (o_a),
    .o_b           (o_b),
    .o_validInput  (o_validInput),
    .i_c           (i_c),
    .i_validResult (i_validResult)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic operand_t identityM();
    operand_t m = '0;
    for (int i = 0; i < N; i++) m[i][i] = 8'd1;
    return m;
  endfunction

  function automatic operand_t rampM(input int base);
    operand_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = 8'(base + 4 * i + j);
    return m;
  endfunction

  function automatic operand_t fillM(input logic [7:0] v);
    operand_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic result_t widen(input operand_t b);
    result_t c;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) c[i][j] = {24'd0, b[i][j]};
    return c;
  endfunction

  function automatic result_t fillC(input logic [31:0] v);
    result_t c;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) c[i][j] = v;
    return c;
  endfunction

  function automatic result_t matMul(input operand_t a, input operand_t b);
    result_t c;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c[i][j] = '0;
        for (int k = 0; k < N; k++) c[i][j] = c[i][j] + 32'(a[i][k]) * 32'(b[k][j]);
      end
    return c;
  endfunction

  // Array stand-in: result LAT cycles after the launch pulse unless disabled.
  initial begin : arrayModel
    logic    armed;
    int      cnt;
    int      staleSeen;
    result_t pendC;
    armed = 1'b0;
    cnt = 0;
    staleSeen = 0;
    pendC = '0;
    i_validResult = 1'b0;
    i_c = '0;
    forever begin
      @(negedge i_clk);
      if (i_arst) armed = 1'b0;
      else if (o_validInput && arrayEnable) begin
        armed = 1'b1;
        cnt   = LAT;
        pendC = matMul(o_a, o_b);
      end
      @(posedge i_clk);
      #1;
      i_validResult = 1'b0;
      if (staleReq != staleSeen) begin
        staleSeen     = staleReq;
        i_c           = fillC(32'd99);
        i_validResult = 1'b1;
      end else if (armed) begin
        if (cnt == 0) begin
          i_c           = pendC;
          i_validResult = 1'b1;
          armed         = 1'b0;
        end else cnt--;
      end
    end
  end

  // Monitor: pops the scoreboard on every response handshake.
  initial begin : monitor
    expT          e;
    logic [R-1:0] ev;
    int           fi;
    forever begin
      @(negedge i_clk);
      if (o_validInput) pulseCount++;
      if ((o_rspValid & i_rspReady) != '0) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected response", 64'(o_rspValid), 64'(0));
        end else begin
          e  = expQ.pop_front();
          ev = '0;
          ev[e.id] = 1'b1;
          checkOutput("rspValid owner", 64'(o_rspValid), 64'(ev));
          checkOutput("rspErr", 64'(o_rspErr), 64'(e.err));
          fi = -1;
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
              if (fi < 0 && o_rspC[i][j] !== e.c[i][j]) fi = i * N + j;
          if (fi < 0) checkOutput("rspC", 64'(o_rspC[0][0]), 64'(e.c[0][0]));
          else checkOutput("rspC", 64'(o_rspC[fi / N][fi % N]), 64'(e.c[fi / N][fi % N]));
        end
      end
    end
  end

  task automatic pushExp(input int id, input logic err, input result_t c);
    expT e;
    e.id  = id;
    e.err = err;
    e.c   = c;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input int k, input operand_t a, input operand_t b);
    i_reqA[k]     = a;
    i_reqB[k]     = b;
    i_reqValid[k] = 1'b1;
  endtask

  // Returns at the negedge of the LAUNCH cycle that follows the grant.
  task automatic waitGrant(input int expIdx, input string name, input bit keep);
    logic [R-1:0] g;
    logic [R-1:0] ev;
    int           cyc;
    cyc = 0;
    ev  = '0;
    ev[expIdx] = 1'b1;
    @(negedge i_clk);
    while (o_reqReady == '0 && cyc < 300) begin
      @(negedge i_clk);
      cyc++;
    end
    g = o_reqReady;
    checkOutput({name, " grant"}, 64'(g), 64'(ev));
    @(posedge i_clk);
    #1;
    if (!keep) i_reqValid = i_reqValid & ~g;
    @(negedge i_clk);
    checkOutput({name, " launch"}, 64'(o_validInput), 64'(1));
  endtask

  task automatic waitResponse(input string name);
    int cyc;
    cyc = 0;
    while (expQ.size() != 0 && cyc < 300) begin
      @(posedge i_clk);
      cyc++;
    end
    #1;
    checkOutput({name, " drained"}, 64'(expQ.size()), 64'(0));
  endtask

  task automatic doReset();
    @(posedge i_clk);
    #1 i_arst = 1'b1;
    @(posedge i_clk);
    #1 i_arst = 1'b0;
  endtask

  initial begin : stimulus
    int pulseBase;
    int cyc;
    int badV, badC, badR, badL;
    i_arst      = 1'b1;
    i_reqValid  = '0;
    i_reqA      = '0;
    i_reqB      = '0;
    i_rspReady  = '1;
    arrayEnable = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_arst = 1'b0;

    @(negedge i_clk);
    checkOutput("reset reqReady", 64'(o_reqReady), 64'(0));
    checkOutput("reset rspValid", 64'(o_rspValid), 64'(0));
    checkOutput("reset validInput", 64'(o_validInput), 64'(0));
    checkOutput("reset rspErr", 64'(o_rspErr), 64'(0));
    checkOutput("reset o_a nonzero", 64'(o_a != '0), 64'(0));
    checkOutput("reset rspC nonzero", 64'(o_rspC != '0), 64'(0));

    $display("[TB] single job");
    @(posedge i_clk);
    #1;
    pulseBase = pulseCount;
    pushExp(0, 1'b0, widen(rampM(0)));
    applyStimulus(0, identityM(), rampM(0));
    waitGrant(0, "single", 1'b0);
    waitResponse("single");
    repeat (2) @(posedge i_clk);
    #1 checkOutput("single pulses", 64'(pulseCount - pulseBase), 64'(1));

    $display("[TB] simultaneous requests");
    doReset();
    pushExp(0, 1'b0, widen(rampM(100)));
    pushExp(1, 1'b0, widen(rampM(200)));
    applyStimulus(0, identityM(), rampM(100));
    applyStimulus(1, identityM(), rampM(200));
    waitGrant(0, "sim r0", 1'b0);
    waitGrant(1, "sim r1", 1'b0);
    waitResponse("sim");

    $display("[TB] alternation");
    pushExp(0, 1'b0, widen(rampM(10)));
    pushExp(1, 1'b0, widen(rampM(20)));
    pushExp(0, 1'b0, widen(rampM(10)));
    pushExp(1, 1'b0, widen(rampM(20)));
    applyStimulus(0, identityM(), rampM(10));
    applyStimulus(1, identityM(), rampM(20));
    waitGrant(0, "alt0", 1'b1);
    waitGrant(1, "alt1", 1'b1);
    waitGrant(0, "alt2", 1'b1);
    waitGrant(1, "alt3", 1'b1);
    @(posedge i_clk);
    #1 i_reqValid = '0;
    waitResponse("alt");

    $display("[TB] response backpressure");
    i_rspReady = '0;
    pushExp(0, 1'b0, widen(rampM(30)));
    applyStimulus(0, identityM(), rampM(30));
    waitGrant(0, "bp r0", 1'b0);
    pushExp(1, 1'b0, widen(rampM(40)));
    applyStimulus(1, identityM(), rampM(40));
    cyc = 0;
    while (o_rspValid == '0 && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
    end
    checkOutput("bp rsp arrival", 64'(o_rspValid), 64'(2'b01));
    badV = 0; badC = 0; badR = 0; badL = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (o_rspValid !== 2'b01) badV++;
      if (o_rspC !== widen(rampM(30))) badC++;
      if (o_reqReady !== '0) badR++;
      if (o_validInput !== 1'b0) badL++;
    end
    checkOutput("bp rspValid held", 64'(badV), 64'(0));
    checkOutput("bp rspC held", 64'(badC), 64'(0));
    checkOutput("bp reqReady low", 64'(badR), 64'(0));
    checkOutput("bp no launch", 64'(badL), 64'(0));
    @(posedge i_clk);
    #1 i_rspReady = '1;
    waitGrant(1, "bp r1", 1'b0);
    waitResponse("bp");

    $display("[TB] timeout");
    arrayEnable = 1'b0;
    pulseBase = pulseCount;
    pushExp(0, 1'b1, fillC(32'd0));
    applyStimulus(0, identityM(), rampM(50));
    waitGrant(0, "timeout", 1'b0);
    cyc = 0;
    do begin
      @(negedge i_clk);
      cyc++;
    end while (o_rspValid == '0 && cyc < 200);
    checkOutput("timeout latency", 64'(cyc), 64'(TIMEOUT + 1));
    waitResponse("timeout");
    checkOutput("timeout pulses", 64'(pulseCount - pulseBase), 64'(1));
    staleReq++;
    badV = 0;
    repeat (6) begin
      @(negedge i_clk);
      if (o_rspValid != '0 || o_validInput) badV++;
    end
    checkOutput("stale strobe ignored", 64'(badV), 64'(0));
    @(posedge i_clk);
    #1 arrayEnable = 1'b1;

    $display("[TB] reset mid-busy");
    applyStimulus(1, identityM(), rampM(60));
    waitGrant(1, "rst job", 1'b0);
    repeat (3) @(posedge i_clk);
    #1 i_arst = 1'b1;
    @(posedge i_clk);
    #1 i_arst = 1'b0;
    @(negedge i_clk);
    checkOutput("rst rspValid", 64'(o_rspValid), 64'(0));
    checkOutput("rst validInput", 64'(o_validInput), 64'(0));
    checkOutput("rst reqReady", 64'(o_reqReady), 64'(0));
    checkOutput("rst rspErr", 64'(o_rspErr), 64'(0));
    checkOutput("rst o_a nonzero", 64'(o_a != '0), 64'(0));
    checkOutput("rst rspC nonzero", 64'(o_rspC != '0), 64'(0));
    badV = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_rspValid != '0 || o_validInput) badV++;
    end
    checkOutput("rst no response", 64'(badV), 64'(0));
    @(posedge i_clk);
    #1;
    pushExp(0, 1'b0, widen(rampM(70)));
    applyStimulus(0, identityM(), rampM(70));
    applyStimulus(1, identityM(), rampM(80));
    waitGrant(0, "post-reset", 1'b0);
    @(posedge i_clk);
    #1 i_reqValid = '0;
    waitResponse("post-reset");

    $display("[TB] saturation");
    pushExp(0, 1'b0, fillC(32'd260100));
    applyStimulus(0, fillM(8'd255), fillM(8'd255));
    waitGrant(0, "sat", 1'b0);
    waitResponse("sat");

    checkOutput("scoreboard empty", 64'(expQ.size()), 64'(0));
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
